// File: rtl/pc_gen_ras.sv
// Fetch PC generator: trap/stall/EX-redirect/RAS/predicted next-PC selection
// with a small circular return-address stack fed by fetch predecode.
module pc_gen_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_vector,
  input  logic                         ex_redirect,
  input  logic                         ex_jump_reg,
  input  logic [XLEN-1:0]              ex_alu_result,
  input  logic                         ex_branch_taken,
  input  logic [XLEN-1:0]              ex_branch_target,
  input  logic [XLEN-1:0]              ex_pc_next,
  input  logic [XLEN-1:0]              pred_target,
  input  logic                         pred_call,
  input  logic                         pred_ret,
  output logic [XLEN-1:0]              pc_o,
  output logic                         flush_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] PcMask   = ~XLEN'(1);
  localparam logic [XLEN-1:0] ResetPc  = RESET_PC & PcMask;
  localparam logic [CW-1:0]   CountMax = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, next_raw;
  logic            flush_q, flush_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, ras_waddr;
  logic            ras_we;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic            advance, cnt_nz;

  // ptr_q is the next free slot; the top of stack sits just below it.
  assign top_idx = ptr_q - PW'(1);
  assign cnt_nz  = (count_q != '0);
  assign advance = !trap_valid && !stall && !ex_redirect;

  always_comb begin
    next_raw = pred_target;
    flush_d  = 1'b0;
    if (trap_valid) begin
      next_raw = trap_vector;
      flush_d  = 1'b1;
    end else if (stall) begin
      next_raw = pc_q;
    end else if (ex_redirect) begin
      flush_d = 1'b1;
      if (ex_jump_reg)          next_raw = ex_alu_result;
      else if (ex_branch_taken) next_raw = ex_branch_target;
      else                      next_raw = ex_pc_next;
    end else if (pred_ret && cnt_nz) begin
      next_raw = ras_q[top_idx];
    end
    pc_d = next_raw & PcMask;
  end

  always_comb begin
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (trap_valid) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (advance) begin
      if (pred_call && pred_ret && cnt_nz) begin
        ras_we    = 1'b1;
        ras_waddr = top_idx;
      end else if (pred_call) begin
        // A full stack overwrites its oldest entry, which lives at ptr_q.
        ras_we    = 1'b1;
        ras_waddr = ptr_q;
        ptr_d     = ptr_q + PW'(1);
        if (count_q != CountMax) count_d = count_q + CW'(1);
      end else if (pred_ret && cnt_nz) begin
        ptr_d   = top_idx;
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= ResetPc;
      flush_q <= 1'b0;
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  // Entry storage is unreset; entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (ras_we && reset) ras_q[ras_waddr] <= pc_q + XLEN'(4);
  end

  assign pc_o        = pc_q;
  assign flush_o     = flush_q;
  assign ras_count_o = count_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: expected fetch state is queued per step and
// popped/compared one time unit after the clock edge.
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, trap_valid, ex_redirect, ex_jump_reg, ex_branch_taken;
  logic        pred_call, pred_ret;
  logic [31:0] trap_vector, ex_alu_result, ex_branch_target, ex_pc_next, pred_target;
  logic [31:0] pc_o;
  logic        flush_o;
  logic [2:0]  ras_count_o;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  pc_gen_ras #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .RAS_DEPTH (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .trap_valid       (trap_valid),
    .trap_vector      (trap_vector),
    .ex_redirect      (ex_redirect),
    .ex_jump_reg      (ex_jump_reg),
    .ex_alu_result    (ex_alu_result),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .ex_pc_next       (ex_pc_next),
    .pred_target      (pred_target),
    .pred_call        (pred_call),
    .pred_ret         (pred_ret),
    .pc_o             (pc_o),
    .flush_o          (flush_o),
    .ras_count_o      (ras_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input logic [31:0] pc, input logic [2:0] cnt,
                           input logic flush);
    check({tag, ".pc"}, 64'(pc_o), 64'(pc));
    check({tag, ".cnt"}, 64'(ras_count_o), 64'(cnt));
    check({tag, ".flush"}, 64'(flush_o), 64'(flush));
  endtask

  // Queue the expectation for this step, clock once, then compare.
  task automatic tick(input string tag, input logic [31:0] pc, input logic [2:0] cnt,
                      input logic flush);
    exp_t e;
    e.tag = tag; e.pc = pc; e.cnt = cnt; e.flush = flush;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_now(e.tag, e.pc, e.cnt, e.flush);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; trap_valid = 1'b0; trap_vector = '0;
    ex_redirect = 1'b0; ex_jump_reg = 1'b0; ex_alu_result = '0;
    ex_branch_taken = 1'b0; ex_branch_target = '0; ex_pc_next = '0;
    pred_call = 1'b0; pred_ret = 1'b0; pred_target = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 32'h0, 3'd0, 1'b0);
    reset = 1'b1;
    tick("seq", 32'h4, 3'd0, 1'b0);

    // Single call / return pair, then an underflowing return.
    pred_target = 32'h100;                  tick("to100", 32'h100, 3'd0, 1'b0);
    pred_call = 1'b1; pred_target = 32'h800; tick("call", 32'h800, 3'd1, 1'b0);
    pred_call = 1'b0; pred_ret = 1'b1; pred_target = 32'h900;
    tick("ret", 32'h104, 3'd0, 1'b0);
    tick("ret_empty", 32'h900, 3'd0, 1'b0);

    // Five calls into a 4-deep stack, then five returns.
    pred_ret = 1'b0; pred_target = 32'h10; tick("to10", 32'h10, 3'd0, 1'b0);
    pred_call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      pred_target = 32'(16 * (i + 1));
      tick($sformatf("call%0d", i), pred_target, (i > 4) ? 3'd4 : 3'(i), 1'b0);
    end
    pred_call = 1'b0; pred_ret = 1'b1; pred_target = 32'hA00;
    tick("ret1", 32'h54, 3'd3, 1'b0);
    tick("ret2", 32'h44, 3'd2, 1'b0);
    tick("ret3", 32'h34, 3'd1, 1'b0);
    tick("ret4", 32'h24, 3'd0, 1'b0);
    tick("ret5", 32'hA00, 3'd0, 1'b0);

    // Simultaneous call+return: push alone when empty, else replace top.
    pred_call = 1'b1; pred_target = 32'hB00; tick("cr_empty", 32'hB00, 3'd1, 1'b0);
    pred_target = 32'hC00;                   tick("cr_top", 32'hA04, 3'd1, 1'b0);
    pred_call = 1'b0; pred_target = 32'hD00; tick("cr_ret", 32'hB04, 3'd0, 1'b0);

    // Stall beats EX redirect and predecode.
    pred_ret = 1'b0; pred_call = 1'b1; pred_target = 32'hE00;
    stall = 1'b1; ex_redirect = 1'b1; ex_pc_next = 32'h88;
    tick("stall", 32'hB04, 3'd0, 1'b0);
    stall = 1'b0; ex_redirect = 1'b0; pred_target = 32'h300;
    tick("call300", 32'h300, 3'd1, 1'b0);

    // Trap beats stall and redirect, clears the stack.
    stall = 1'b1; ex_redirect = 1'b1; trap_valid = 1'b1; trap_vector = 32'h200;
    tick("trap", 32'h200, 3'd0, 1'b1);
    stall = 1'b0; ex_redirect = 1'b0; trap_valid = 1'b0; pred_call = 1'b0;
    pred_target = 32'h204;
    tick("post_trap", 32'h204, 3'd0, 1'b0);

    // EX redirects ignore predecode and leave the stack untouched.
    pred_call = 1'b1; pred_target = 32'h600; tick("call600", 32'h600, 3'd1, 1'b0);
    pred_call = 1'b0; pred_ret = 1'b1;
    ex_redirect = 1'b1; ex_jump_reg = 1'b1; ex_alu_result = 32'h1235;
    tick("jalr", 32'h1234, 3'd1, 1'b1);
    ex_jump_reg = 1'b0; ex_branch_taken = 1'b0; ex_pc_next = 32'h88;
    tick("not_taken", 32'h88, 3'd1, 1'b1);
    ex_branch_taken = 1'b1; ex_branch_target = 32'h4567;
    tick("taken", 32'h4566, 3'd1, 1'b1);
    ex_redirect = 1'b0; pred_ret = 1'b0; pred_target = 32'h701;
    tick("odd_pred", 32'h700, 3'd1, 1'b0);

    // Asynchronous reset in the middle of a pop.
    pred_ret = 1'b1; pred_target = 32'h40;
    #3;
    reset = 1'b0;
    #1;
    check_now("async_rst", 32'h0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check_now("rst_hold", 32'h0, 3'd0, 1'b0);
    reset = 1'b1;
    tick("rst_release", 32'h40, 3'd0, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
